debug_overlay_v2: RTL

DEBUG_OVERLAY_V2 -- requirements
Module: debug_overlay_v2

---
 rtl/debug_overlay_v2_pkg.sv | 28 ++
 rtl/debug_snapshot_channel.sv | 43 ++++
 rtl/fixed_point_params.v | 13 +
 rtl/debug_overlay_v2.sv | 122 ++++++++++++
 4 files changed

// File: rtl/debug_overlay_v2_pkg.sv
// rtl/debug_overlay_v2_pkg.sv - shared types, constants and colour helper for the debug overlay
// Purpose: fixed-point widths, pixel classification enum and cell colour function.
// Ports: none (package).
`include "fixed_point_params.v"

package debug_overlay_v2_pkg;

  localparam int QM  = `Qm;
  localparam int QN  = `Qn;
  localparam int QMN = `Qmn;

  localparam logic [5:0] RGB_OFF     = 6'b000000;
  localparam logic [5:0] RGB_DIVIDER = 6'b101010;

  typedef enum logic [1:0] {
    PIX_OFF,
    PIX_GRID,
    PIX_DIVIDER,
    PIX_CELL
  } pix_kind_e;

  // Grey when settled, red while the channel is still highlighted after a change.
  function automatic logic [5:0] cell_rgb(input logic bit_on, input logic highlight);
    if (highlight) return bit_on ? 6'b110000 : 6'b010000;
    return bit_on ? 6'b111111 : 6'b010101;
  endfunction

endpackage

// File: rtl/debug_snapshot_channel.sv
// rtl/debug_snapshot_channel.sv - per-channel frame snapshot and change-highlight counter
// Purpose: captures one channel value on each load and restarts a hold counter
//   whenever the captured value differs from the previous snapshot.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   i_load     : capture strobe (frame start, not frozen)
//   i_data     : live channel value
//   o_snap     : value captured at the last load
//   o_age      : frames left in highlight (0 = settled)
module debug_snapshot_channel #(
  parameter int W           = 24,
  parameter int HOLD_FRAMES = 30,
  parameter int AW          = $clog2(HOLD_FRAMES + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_load,
  input  logic [W-1:0]  i_data,
  output logic [W-1:0]  o_snap,
  output logic [AW-1:0] o_age
);

  logic [W-1:0]  r_snap;
  logic [AW-1:0] r_age;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_snap <= '0;
      r_age  <= '0;
    end else if (i_load) begin
      r_snap <= i_data;
      if (i_data != r_snap) begin
        r_age <= AW'(HOLD_FRAMES);
      end else if (r_age != '0) begin
        r_age <= r_age - 1'b1;
      end
    end
  end

  assign o_snap = r_snap;
  assign o_age  = r_age;

endmodule

// File: rtl/fixed_point_params.v
// rtl/fixed_point_params.v - shared fixed-point format macros
// Purpose: single definition of the Qm.n format used across the codebase.
//   `Qm  : integer bits
//   `Qn  : fraction bits
//   `Qmn : total bits
//   `F   : declaration fragment for a fixed-point value
`ifndef FIXED_POINT_PARAMS_V
`define FIXED_POINT_PARAMS_V
`define Qm 12
`define Qn 12
`define Qmn (`Qm + `Qn)
`define F signed [`Qmn-1:0]
`endif

// File: rtl/debug_overlay_v2.sv
// rtl/debug_overlay_v2.sv - right-aligned bit-grid overlay of fixed-point debug channels
// Purpose: draws each channel snapshot as one row of bit cells with gridlines,
//   an integer/fraction divider and red highlight of recently changed rows.
// Ports:
//   clk, reset       : clock, asynchronous active-high reset
//   hpos, vpos       : current pixel column / row
//   frame_start      : one-cycle pulse per frame, loads snapshots
//   freeze           : holds snapshots and highlight counters while high
//   channels         : live values, channel i at [i*Qmn +: Qmn]
//   in_debug_overlay : registered region flag (one cycle latency)
//   debug_rgb        : registered RRGGBB colour (one cycle latency)
`include "fixed_point_params.v"

module debug_overlay_v2
  import debug_overlay_v2_pkg::*;
#(
  parameter int H_VIEW      = 640,
  parameter int DEBUG_SCALE = 3,
  parameter int CHANNELS    = 6,
  parameter int HOLD_FRAMES = 30
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [9:0]              hpos,
  input  logic [9:0]              vpos,
  input  logic                    frame_start,
  input  logic                    freeze,
  input  logic [CHANNELS*QMN-1:0] channels,
  output logic                    in_debug_overlay,
  output logic [5:0]              debug_rgb
);

  localparam int AW = $clog2(HOLD_FRAMES + 1);
  localparam int DOHS = H_VIEW - (QMN << DEBUG_SCALE) - 1;
  localparam logic [10:0] DOHS_W = 11'(DOHS);
  localparam logic [10:0] V_LAST = 11'(CHANNELS << DEBUG_SCALE);
  localparam logic [10:0] DIV_H  = 11'(QM << DEBUG_SCALE);

  logic            w_load;
  logic [QMN-1:0]  w_snap [CHANNELS];
  logic [AW-1:0]   w_age  [CHANNELS];

  assign w_load = frame_start & ~freeze;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    debug_snapshot_channel #(
      .W           (QMN),
      .HOLD_FRAMES (HOLD_FRAMES),
      .AW          (AW)
    ) u_chan (
      .clk    (clk),
      .reset  (reset),
      .i_load (w_load),
      .i_data (channels[i*QMN +: QMN]),
      .o_snap (w_snap[i]),
      .o_age  (w_age[i])
    );
  end

  logic signed [10:0] w_h;
  logic               w_region;
  logic [9:0]         w_row;
  logic [9:0]         w_col;
  logic               w_grid;
  logic [QMN-1:0]     w_sel_snap;
  logic               w_sel_hl;
  logic               w_bit;
  pix_kind_e          w_kind;
  logic [5:0]         w_rgb;

  // The closing gridline at v == CHANNELS<<DEBUG_SCALE belongs to the region.
  assign w_h      = $signed({1'b0, hpos} - DOHS_W);
  assign w_region = !w_h[10] && ({1'b0, vpos} <= V_LAST);
  assign w_row    = vpos >> DEBUG_SCALE;
  assign w_col    = w_h[9:0] >> DEBUG_SCALE;
  assign w_grid   = (w_h[DEBUG_SCALE-1:0] == '0) || (vpos[DEBUG_SCALE-1:0] == '0);

  always_comb begin
    w_sel_snap = '0;
    w_sel_hl   = 1'b0;
    w_bit      = 1'b0;
    w_kind     = PIX_OFF;
    w_rgb      = RGB_OFF;
    // Row and column selection done by compare so out-of-range indices yield 0.
    for (int i = 0; i < CHANNELS; i++) begin
      if (w_row == 10'(i)) begin
        w_sel_snap = w_snap[i];
        w_sel_hl   = (w_age[i] != '0);
      end
    end
    // Column 0 shows the MSB.
    for (int j = 0; j < QMN; j++) begin
      if (w_col == 10'(QMN - 1 - j)) w_bit = w_sel_snap[j];
    end
    if (w_region && (w_row < 10'(CHANNELS))) begin
      if (w_grid) w_kind = (w_h == DIV_H) ? PIX_DIVIDER : PIX_GRID;
      else        w_kind = PIX_CELL;
    end
    case (w_kind)
      PIX_DIVIDER: w_rgb = RGB_DIVIDER;
      PIX_CELL:    w_rgb = cell_rgb(w_bit, w_sel_hl);
      default:     w_rgb = RGB_OFF;
    endcase
  end

  logic       r_in_overlay;
  logic [5:0] r_rgb;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_in_overlay <= 1'b0;
      r_rgb        <= '0;
    end else begin
      r_in_overlay <= w_region;
      r_rgb        <= w_rgb;
    end
  end

  assign in_debug_overlay = r_in_overlay;
  assign debug_rgb        = r_rgb;

endmodule
